rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one resource (the 2-bit index encode path) among N

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_arbiter_if.sv | 35 +++
 rtl/rr_pick.sv | 44 ++++
 rtl/rr_arbiter.sv | 89 ++++++++
 tb/tb_rr_arbiter.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//  - arb_state_e : FSM encoding (ST_IDLE / ST_BUSY)
//  - DEF_N, DEF_IDX_W : default requester count and grant-index width
package arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_IDX_W = 2;

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
//  req       requester -> arbiter, level-sensitive request vector
//  gnt       arbiter -> requester, one-hot grant
//  gnt_idx   arbiter -> requester, binary index of gnt (valid with gnt_valid)
//  gnt_valid arbiter -> requester, high while a grant is held
//  timeout   arbiter -> requester, 1-cycle pulse on forced revoke
// master: requester side; slave: arbiter side.
interface rr_arbiter_if #(
    parameter int unsigned N     = arb_pkg::DEF_N,
    parameter int unsigned IDX_W = arb_pkg::DEF_IDX_W
) ();

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//  req      in   N      request vector
//  ptr      in   IDX_W  index with highest priority this round
//  pick_oh  out  N      one-hot winner (zero when req == 0)
//  pick_idx out  IDX_W  binary index of pick_oh
//  pick_any out  1      any request present
// Rotates req so ptr lands at bit 0, takes the lowest set bit, rotates back.
module rr_pick #(
    parameter int unsigned N     = arb_pkg::DEF_N,
    parameter int unsigned IDX_W = arb_pkg::DEF_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] sel_dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   sel;

    always_comb begin
        // Doubling the vector turns the rotation into a plain part-select / shift.
        req_dbl  = {req, req};
        rot      = req_dbl[ptr +: N];
        sel      = rot & (~rot + ONE);
        sel_dbl  = {sel, sel} << ptr;
        pick_oh  = sel_dbl[2*N-1:N];
        pick_any = |req;

        // pick_oh is one-hot, so OR-ing indices is an exact encode.
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_oh[i]) begin
                pick_idx = pick_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold and optional hold timeout.
//  clk       in   1      rising-edge clock
//  rst       in   1      asynchronous active-high reset
//  bus       slave modport of rr_arbiter_if (req in; gnt, gnt_idx, gnt_valid,
//            timeout out, all outputs registered)
// A grant is held until its owner drops req or MAX_HOLD cycles elapse
// (MAX_HOLD = 0 disables the timeout). Every grant is followed by one idle
// cycle, and the search pointer moves past the last owner.
module rr_arbiter #(
    parameter int unsigned N        = arb_pkg::DEF_N,
    parameter int unsigned IDX_W    = arb_pkg::DEF_IDX_W,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic         clk,
    input logic         rst,
    rr_arbiter_if.slave bus
);

    import arb_pkg::*;

    localparam int unsigned      HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0]    HOLD_SAT  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

    arb_state_e       state;
    logic [IDX_W-1:0] ptr;
    logic [HW-1:0]    hold_cnt;

    logic [N-1:0]     pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req;
    logic             hold_expired;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // gnt is one-hot while BUSY, so masking avoids a variable index.
    assign owner_req    = |(bus.req & bus.gnt);
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            hold_cnt      <= '0;
            bus.gnt       <= '0;
            bus.gnt_idx   <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        bus.gnt       <= pick_oh;
                        bus.gnt_idx   <= pick_idx;
                        bus.gnt_valid <= 1'b1;
                        hold_cnt      <= '0;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!owner_req || hold_expired) begin
                        // A drop wins over a coincident expiry: no timeout pulse.
                        bus.timeout   <= owner_req;
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
                        ptr           <= (bus.gnt_idx == LAST_IDX) ? '0 : bus.gnt_idx + 1'b1;
                        state         <= ST_IDLE;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;

    logic clk;
    logic clk_en;
    logic rst;

    int compared;
    int mismatched;

    rr_arbiter_if #(.N(4), .IDX_W(2)) bus ();

    rr_arbiter #(
        .N        (4),
        .IDX_W    (2),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       valid;
        logic       tmo;
    } vec_t;

    vec_t tbl[32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] idx,
                             input logic v, input logic t);
        check({name, ".gnt"}, 32'(bus.gnt), 32'(g));
        check({name, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
        check({name, ".timeout"}, 32'(bus.timeout), 32'(t));
        if (v) check({name, ".gnt_idx"}, 32'(bus.gnt_idx), 32'(idx));
    endtask

    // Invariant: gnt zero/one-hot and gnt_valid tracks |gnt.
    always @(negedge clk) begin
        if (clk_en && !rst) begin
            check("inv.onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            check("inv.valid_eq_or", 32'(bus.gnt_valid), 32'(|bus.gnt));
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        clk_en     = 1'b0;
        rst        = 1'b0;
        bus.req    = 4'b0000;

        // req -> expected {gnt, idx, valid, timeout}, starting from reset (ptr=0)
        tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[2]  = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0}; // ptr=3 wraps to 0
        tbl[3]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[6]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0}; // search starts at 3
        tbl[9]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // ptr 3 -> 0
        tbl[10] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[12] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[13] = '{4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[14] = '{4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1}; // timeout
        tbl[15] = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[16] = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[17] = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[18] = '{4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[19] = '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0}; // drop on expiry: release
        tbl[20] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[21] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[22] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[23] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[24] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[25] = '{4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1}; // sole requester times out
        tbl[26] = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}; // ...and is re-granted
        tbl[27] = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0}; // non-owners ignored
        tbl[28] = '{4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[29] = '{4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[30] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[31] = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};

        // Async reset with the clock stopped
        #2 rst = 1'b1;
        #1;
        check_out("reset_noclk", 4'b0000, 2'd0, 1'b0, 1'b0);
        check("reset_noclk.gnt_idx", 32'(bus.gnt_idx), 32'd0);
        clk_en = 1'b1;
        #1 rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            bus.req = tbl[i].req;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].idx, tbl[i].valid, tbl[i].tmo);
        end

        // Fair rotation: everyone requesting, owner drops after 2 granted cycles
        rst = 1'b1;
        #1 rst = 1'b0;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            step();
            check_out($sformatf("rot%0d.c1", k), oh, 2'(k % 4), 1'b1, 1'b0);
            step();
            check_out($sformatf("rot%0d.c2", k), oh, 2'(k % 4), 1'b1, 1'b0);
            bus.req = ~oh;
            step();
            check_out($sformatf("rot%0d.idle", k), 4'b0000, 2'd0, 1'b0, 1'b0);
            bus.req = 4'b1111;
        end

        // Mid-grant async reset; ptr is 1 here, grant goes to 3
        bus.req = 4'b1000;
        step();
        check_out("pre_rst", 4'b1000, 2'd3, 1'b1, 1'b0);
        #1 rst = 1'b1;
        #1;
        check_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.req = 4'b1001;
        step();
        check_out("post_rst_ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        bus.req = 4'b0000;
        step();
        check_out("post_rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
        bus.req = 4'b1000;
        step();
        check_out("post_rst_req3", 4'b1000, 2'd3, 1'b1, 1'b0);
        bus.req = 4'b0000;
        step();
        check_out("post_rst_rel3", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
